// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
  localparam int XLEN = 32;
  localparam int FETCH_Q_DEPTH = 3;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
  function automatic logic [1:0] q_next(input logic [1:0] p);
    return (p == 2'(FETCH_Q_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 3-entry circular FIFO of fetched words with synchronous flush.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);
  fetch_entry_t mem_q [FETCH_Q_DEPTH];
  fetch_entry_t mem_d [FETCH_Q_DEPTH];
  logic [1:0] rd_q, rd_d, wr_q, wr_d, cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push && !flush) mem_d[wr_q] = din;
    rd_d  = flush ? 2'd0 : pop ? q_next(rd_q) : rd_q;
    wr_d  = flush ? 2'd0 : push ? q_next(wr_q) : wr_q;
    cnt_d = flush ? 2'd0 : cnt_q + 2'(push) - 2'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = cnt_q == 2'(FETCH_Q_DEPTH);
  assign empty = cnt_q == 2'd0;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, issues IMEM reads under queue credit, handles redirects and misaligned-target faults.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_q,
  output logic [DATA_W-1:0] instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              fault
);
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, ipc_q, ipc_d;
  logic inflight_q, inflight_d, dead_q, dead_d, fault_q, fault_d;
  logic issue, flush, kill, push, pop, credit, misaligned;
  fetch_entry_t q_din, q_head;
  logic [1:0] q_cnt;
  logic q_full, q_empty;
  always_comb begin
    misaligned  = |redirect_pc[1:0];
    flush       = redirect && state_q == RUN;
    credit      = !q_full && !(q_cnt == 2'(FETCH_Q_DEPTH - 1) && inflight_q);
    issue       = state_q == RUN && !redirect && credit;
    kill        = dead_q || flush;
    push        = inflight_q && !kill;
    instr_valid = !q_empty && !redirect && state_q != HALT;
    pop         = instr_valid && instr_ready;
    state_d     = state_q == BOOT ? RUN : (flush && misaligned) ? HALT : state_q;
    pc_d        = flush ? redirect_pc : issue ? pc_q + 32'd4 : pc_q;
    ipc_d       = issue ? pc_q : ipc_q;
    inflight_d  = issue;
    // a killed word stays dead until a fresh issue replaces it
    dead_d      = !issue && kill;
    fault_d     = fault_q || (flush && misaligned);
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      ipc_q      <= '0;
      inflight_q <= 1'b0;
      dead_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ipc_q      <= ipc_d;
      inflight_q <= inflight_d;
      dead_q     <= dead_d;
      fault_q    <= fault_d;
    end
  end
  assign q_din = '{instr: imem_q, pc: ipc_q};
  fetch_queue u_queue (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (q_din),
    .dout  (q_head),
    .count (q_cnt),
    .full  (q_full),
    .empty (q_empty)
  );
  assign imem_addr = pc_q[ADDR_W+1:2];
  assign instr     = q_head.instr;
  assign instr_pc  = q_head.pc;
  assign fault     = fault_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed checks of fetch_ctrl against a registered IMEM returning A000_0000|addr.
module tb_fetch_ctrl;
  logic        CLK, RESET;
  logic [9:0]  imem_addr;
  logic [31:0] imem_q, instr, instr_pc, redirect_pc;
  logic        instr_valid, instr_ready, redirect, fault;
  int checks = 0;
  int errors = 0;

  fetch_ctrl dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .imem_addr   (imem_addr),
    .imem_q      (imem_q),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fault       (fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) imem_q <= 32'hA000_0000 | 32'(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic head(input string tag, input logic [31:0] i, input logic [31:0] p);
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_instr"}, instr, i);
    check({tag, "_pc"}, instr_pc, p);
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_pc"}, instr_pc, 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
  endtask

  initial begin
    RESET = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    repeat (2) tick();
    // test 1: boot timing and streaming
    reset_vals("rst");
    RESET = 1'b0;
    tick(); check("boot_c1_valid", 32'(instr_valid), 0); check("boot_c1_addr", 32'(imem_addr), 0);
    tick(); check("boot_c2_valid", 32'(instr_valid), 0); check("boot_c2_addr", 32'(imem_addr), 1);
    tick(); head("boot_c3", 32'hA000_0000, 32'h0);
    tick(); head("boot_c4", 32'hA000_0001, 32'h4);
    tick(); head("boot_c5", 32'hA000_0002, 32'h8);
    // test 2: backpressure for 5 cycles
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_addr", 32'(imem_addr), 32'd5);
      head("stall_head", 32'hA000_0002, 32'h8);
    end
    tick(); instr_ready = 1'b1;
    head("resume0", 32'hA000_0002, 32'h8);
    tick(); head("resume1", 32'hA000_0003, 32'hC);
    tick(); head("resume2", 32'hA000_0004, 32'h10);
    tick(); head("resume3", 32'hA000_0005, 32'h14);
    // test 3: redirect while full
    instr_ready = 1'b0;
    repeat (4) tick();
    head("full_head", 32'hA000_0005, 32'h14);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    #1 check("redir_gate", 32'(instr_valid), 0);
    tick(); redirect = 1'b0;
    check("redir_r1_valid", 32'(instr_valid), 0); check("redir_r1_addr", 32'(imem_addr), 32'h10);
    tick(); check("redir_r2_valid", 32'(instr_valid), 0);
    tick(); head("redir_r3", 32'hA000_0010, 32'h40);
    tick(); head("redir_r4", 32'hA000_0011, 32'h44);
    // test 5: wrap at top of IMEM
    redirect = 1'b1; redirect_pc = 32'hFFC;
    tick(); redirect = 1'b0;
    check("wrap_addr_hi", 32'(imem_addr), 32'h3FF);
    tick(); check("wrap_addr_lo", 32'(imem_addr), 32'h0);
    tick(); head("wrap_a", 32'hA000_03FF, 32'hFFC);
    tick(); head("wrap_b", 32'hA000_0000, 32'h1000);
    // test 6: reset with a word in flight and 2 queued
    instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0;
    tick(); redirect = 1'b0;
    repeat (3) tick();
    head("pre_rst", 32'hA000_0000, 32'h0);
    RESET = 1'b1;
    tick(); reset_vals("mid_rst");
    RESET = 1'b0; instr_ready = 1'b1;
    tick(); check("post_rst_c1", 32'(instr_valid), 0);
    tick(); check("post_rst_c2", 32'(instr_valid), 0);
    tick(); head("post_rst_c3", 32'hA000_0000, 32'h0);
    tick(); head("post_rst_c4", 32'hA000_0001, 32'h4);
    // test 4: misaligned redirect halts
    redirect = 1'b1; redirect_pc = 32'h42;
    tick(); redirect = 1'b0;
    check("halt_fault", 32'(fault), 1); check("halt_valid", 32'(instr_valid), 0);
    check("halt_addr", 32'(imem_addr), 32'h10);
    tick(); check("halt_valid2", 32'(instr_valid), 0);
    redirect = 1'b1; redirect_pc = 32'h80;
    tick(); redirect = 1'b0;
    check("halt_ign_addr", 32'(imem_addr), 32'h10); check("halt_ign_fault", 32'(fault), 1);
    tick(); check("halt_valid3", 32'(instr_valid), 0);
    RESET = 1'b1;
    tick(); check("halt_rst_fault", 32'(fault), 0);
    RESET = 1'b0; redirect = 1'b1; redirect_pc = 32'h42;
    tick(); redirect = 1'b0;
    check("boot_redir_fault", 32'(fault), 0); check("boot_redir_addr", 32'(imem_addr), 0);
    tick();
    tick(); head("boot_redir_c3", 32'hA000_0000, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
